// File: rtl/subtractor_8bit_pkg.sv
// Shared ALU definitions: default operand width and flag-register bit positions.
package subtractor_8bit_pkg;

  localparam int WIDTH_DEFAULT = 8;

  // Bit positions of the subtractor status flags inside the ALU flag register
  localparam int FLAG_BORROW = 0;
  localparam int FLAG_OVF    = 1;
  localparam int FLAG_ZERO   = 2;
  localparam int FLAG_COUNT  = 3;

endpackage : subtractor_8bit_pkg

// File: rtl/subtractor_8bit_if.sv
// Operand/result bundle of the registered subtractor.
// The master drives operands and reads results; the slave is the subtractor.
interface subtractor_8bit_if
  import subtractor_8bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;
  logic             out_valid;

  modport master (
    output in_valid, a, b,
    input  d, bout, ovf, zero, out_valid
  );

  modport slave (
    input  in_valid, a, b,
    output d, bout, ovf, zero, out_valid
  );

endinterface : subtractor_8bit_if

// File: rtl/subtractor_8bit_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow arrives from below
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/subtractor_8bit.sv
// Registered WIDTH-bit subtractor: d = a - b with borrow-out, signed overflow
// and zero flags, one cycle of latency and a valid strobe.
module subtractor_8bit
  import subtractor_8bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  subtractor_8bit_if.slave  bus
);

  // Borrow chain: brw_p0[i] is the borrow into bit i; the LSB never borrows in
  logic [WIDTH:0]          brw_p0;
  logic signed [WIDTH-1:0] diff_p0;
  logic                    ovf_p0;
  logic                    zero_p0;

  logic signed [WIDTH-1:0] d_p1;
  logic                    bout_p1;
  logic                    ovf_p1;
  logic                    zero_p1;
  logic                    vld_p1;

  assign brw_p0[0] = 1'b0;

  // Stage p0: ripple-borrow chain of full subtractors
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_subtractor u_fs (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .bin  (brw_p0[i]),
      .d    (diff_p0[i]),
      .bout (brw_p0[i+1])
    );
  end

  // Signed overflow: operands of opposite sign and result sign differs from a
  assign ovf_p0  = (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & (diff_p0[WIDTH-1] ^ bus.a[WIDTH-1]);
  assign zero_p0 = ~|diff_p0;

  // Stage p1: capture result and flags on accepted operands, hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_p1    <= '0;
      bout_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
      zero_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        d_p1    <= diff_p0;
        bout_p1 <= brw_p0[WIDTH];
        ovf_p1  <= ovf_p0;
        zero_p1 <= zero_p0;
      end
    end
  end

  assign bus.d         = d_p1;
  assign bus.bout      = bout_p1;
  assign bus.ovf       = ovf_p1;
  assign bus.zero      = zero_p1;
  assign bus.out_valid = vld_p1;

endmodule : subtractor_8bit

// File: tb/tb_subtractor_8bit.sv
// Bench for subtractor_8bit: directed scenarios plus randomized traffic
// checked against an arithmetic reference model.
module tb_subtractor_8bit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  subtractor_8bit_if #(.WIDTH(8)) bus ();

  subtractor_8bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {d, bout, ovf, zero, out_valid}
  logic [11:0] obs;
  assign obs = {bus.d, bus.bout, bus.ovf, bus.zero, bus.out_valid};

  // Apply one cycle of stimulus and settle just after the capturing edge
  task automatic drive(input logic r, input logic v, input logic [7:0] av, input logic [7:0] bv);
    rst_n        = r;
    bus.in_valid = v;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 8'hFF, 8'h00);
    drive(1'b0, 1'b1, 8'hA5, 8'h93);
    vectors++;
    if (obs !== 12'h000) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", obs, 12'h000);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, 8'hA5, 8'h93);
    vectors++;
    if (obs !== {8'h12, 4'b0001}) begin
      miscompares++;
      $display("FAIL basic_a5_93: got %h want %h", obs, {8'h12, 4'b0001});
    end
    drive(1'b1, 1'b1, 8'hF0, 8'hE0);
    vectors++;
    if (obs !== {8'h10, 4'b0001}) begin
      miscompares++;
      $display("FAIL basic_f0_e0: got %h want %h", obs, {8'h10, 4'b0001});
    end
    drive(1'b1, 1'b0, 8'hxx, 8'hxx);
    vectors++;
    if (obs !== {8'h10, 4'b0000}) begin
      miscompares++;
      $display("FAIL hold_idle: got %h want %h", obs, {8'h10, 4'b0000});
    end
    drive(1'b1, 1'b0, 8'h3C, 8'h11);
    vectors++;
    if (obs !== {8'h10, 4'b0000}) begin
      miscompares++;
      $display("FAIL hold_idle2: got %h want %h", obs, {8'h10, 4'b0000});
    end
  endtask

  task automatic test_borrow_ovf();
    drive(1'b1, 1'b1, 8'h00, 8'h01);
    vectors++;
    if (obs !== {8'hFF, 4'b1001}) begin
      miscompares++;
      $display("FAIL wrap_00_01: got %h want %h", obs, {8'hFF, 4'b1001});
    end
    drive(1'b1, 1'b1, 8'h00, 8'hFF);
    vectors++;
    if (obs !== {8'h01, 4'b1001}) begin
      miscompares++;
      $display("FAIL wrap_00_ff: got %h want %h", obs, {8'h01, 4'b1001});
    end
    drive(1'b1, 1'b1, 8'h80, 8'h01);
    vectors++;
    if (obs !== {8'h7F, 4'b0101}) begin
      miscompares++;
      $display("FAIL ovf_80_01: got %h want %h", obs, {8'h7F, 4'b0101});
    end
    drive(1'b1, 1'b1, 8'h7F, 8'hFF);
    vectors++;
    if (obs !== {8'h80, 4'b1101}) begin
      miscompares++;
      $display("FAIL ovf_7f_ff: got %h want %h", obs, {8'h80, 4'b1101});
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 8'h55, 8'h55);
    vectors++;
    if (obs !== {8'h00, 4'b0011}) begin
      miscompares++;
      $display("FAIL b2b_55_55: got %h want %h", obs, {8'h00, 4'b0011});
    end
    drive(1'b1, 1'b1, 8'h10, 8'h20);
    vectors++;
    if (obs !== {8'hF0, 4'b1001}) begin
      miscompares++;
      $display("FAIL b2b_10_20: got %h want %h", obs, {8'hF0, 4'b1001});
    end
    drive(1'b1, 1'b1, 8'hFF, 8'h00);
    vectors++;
    if (obs !== {8'hFF, 4'b0001}) begin
      miscompares++;
      $display("FAIL b2b_ff_00: got %h want %h", obs, {8'hFF, 4'b0001});
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_d;
    logic       exp_bout, exp_ovf, exp_zero, exp_vld;
    logic [11:0] exp;
    logic [7:0] ra, rb;
    logic       rr, rv;
    int         ia, ib, diff, sdiff;
    exp_d = 8'h00; exp_bout = 1'b0; exp_ovf = 1'b0; exp_zero = 1'b0; exp_vld = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      rr = (i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
      rv = $urandom_range(0, 3) != 0;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (!rv && $urandom_range(0, 3) == 0) begin
        drive(rr, rv, 8'hxx, 8'hxx);
      end else begin
        drive(rr, rv, ra, rb);
      end
      // Reference: plain integer arithmetic on unsigned and signed views
      if (!rr) begin
        exp_d = 8'h00; exp_bout = 1'b0; exp_ovf = 1'b0; exp_zero = 1'b0; exp_vld = 1'b0;
      end else begin
        exp_vld = rv;
        if (rv) begin
          ia       = int'(ra);
          ib       = int'(rb);
          diff     = ia - ib;
          exp_d    = 8'((diff + 256) % 256);
          exp_bout = (ia < ib);
          sdiff    = int'($signed(ra)) - int'($signed(rb));
          exp_ovf  = (sdiff > 127) || (sdiff < -128);
          exp_zero = (exp_d == 8'h00);
        end
      end
      exp = {exp_d, exp_bout, exp_ovf, exp_zero, exp_vld};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL random[%0d] a=%h b=%h v=%b rst_n=%b: got %h want %h",
                 i, ra, rb, rv, rr, obs, exp);
      end
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = 8'h00;
    bus.b        = 8'h00;
    test_reset();
    test_basic();
    test_borrow_ovf();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_subtractor_8bit
